// File: rtl/chipper_eject_inject.sv
// chipper_eject_inject: CHIPPER eject/inject and XY route-compute stage feeding the pdn permutation network.
// Latency: 1 cycle from *_in to *_pdn / ej_*; a pushed local flit is injectable the cycle after its push.
// Backpressure: inj_ready is low while the INJ_DEPTH-entry injection FIFO is full; the link side never stalls.
// Optional feature: define CHIPPER_EI_STATS_EN to add the saturating stat_eject / stat_defl counters.
module chipper_eject_inject #(
  parameter logic [1:0] NODE_X    = 2'd1,
  parameter logic [1:0] NODE_Y    = 2'd1,
  parameter int         INJ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  north_in,
  input  logic [9:0]  south_in,
  input  logic [9:0]  east_in,
  input  logic [9:0]  west_in,
  input  logic        inj_valid,
  input  logic [5:0]  inj_data,
  output logic        inj_ready,
  output logic        ej_valid,
  output logic [5:0]  ej_data,
  output logic [9:0]  north_pdn,
  output logic [9:0]  south_pdn,
  output logic [9:0]  east_pdn,
  output logic [9:0]  west_pdn
`ifdef CHIPPER_EI_STATS_EN
  ,
  output logic [15:0] stat_eject,
  output logic [15:0] stat_defl
`endif
);

  // Flit layout: [9] golden, [8] valid, [7:6] dest_x, [5:4] dest_y, [3:2] payload, [1:0] port
  localparam int PTR_W  = (INJ_DEPTH > 1) ? $clog2(INJ_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int SLOT_E = 0;
  localparam int SLOT_W = 1;
  localparam int SLOT_N = 2;
  localparam int SLOT_S = 3;

  // XY routing: resolve x first, then y; a flit already at this node gets east (0)
  function automatic logic [1:0] route_port(input logic [1:0] dx, input logic [1:0] dy);
    logic [1:0] p;
    p = 2'd0;
    if (dx > NODE_X)      p = 2'd0;
    else if (dx < NODE_X) p = 2'd1;
    else if (dy > NODE_Y) p = 2'd2;
    else if (dy < NODE_Y) p = 2'd3;
    return p;
  endfunction

  // Slot arrays are indexed in arbitration order E, W, N, S
  logic [9:0]       lnk      [4];
  logic [3:0]       is_local;
  logic [3:0]       slot_free;
  logic             ej_hit;
  logic [1:0]       ej_idx;
  logic             inj_hit;
  logic [9:0]       slot_d   [4];
  logic [9:0]       slot_q   [4];
  logic             ej_vld_d, ej_vld_q;
  logic [5:0]       ej_dat_d, ej_dat_q;

  // Injection FIFO state
  logic [5:0]       mem_q    [INJ_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_nonempty;
  logic [5:0]       head;

  // The incoming port field is recomputed here, so those bits are intentionally dropped
  logic             unused_in_port;
  assign unused_in_port = ^{north_in[1:0], south_in[1:0], east_in[1:0], west_in[1:0]};

  assign fifo_nonempty = (count_q != '0);
  assign inj_ready     = (count_q != CNT_W'(INJ_DEPTH));
  assign fifo_push     = inj_valid & inj_ready;
  assign head          = mem_q[rd_ptr_q];

  // Classify link flits and pick at most one local flit to eject (golden first, then E, W, N, S)
  always_comb begin
    lnk[SLOT_E] = east_in;
    lnk[SLOT_W] = west_in;
    lnk[SLOT_N] = north_in;
    lnk[SLOT_S] = south_in;
    is_local    = '0;
    ej_hit      = 1'b0;
    ej_idx      = 2'd0;
    for (int i = 0; i < 4; i++) begin
      is_local[i] = lnk[i][8] && (lnk[i][7:6] == NODE_X) && (lnk[i][5:4] == NODE_Y);
    end
    for (int i = 0; i < 4; i++) begin
      if (!ej_hit && is_local[i] && lnk[i][9]) begin
        ej_hit = 1'b1;
        ej_idx = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (!ej_hit && is_local[i]) begin
        ej_hit = 1'b1;
        ej_idx = 2'(i);
      end
    end
  end

  // Build the next slot contents: route survivors, then drop the FIFO head into the first free slot
  always_comb begin
    ej_vld_d = ej_hit;
    ej_dat_d = ej_hit ? lnk[ej_idx][7:2] : 6'd0;
    inj_hit  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      slot_free[i] = !lnk[i][8] || (ej_hit && (ej_idx == 2'(i)));
      if (slot_free[i]) begin
        slot_d[i] = 10'd0;
      end else begin
        slot_d[i] = {lnk[i][9:2], route_port(lnk[i][7:6], lnk[i][5:4])};
      end
    end
    if (fifo_nonempty) begin
      for (int i = 0; i < 4; i++) begin
        if (!inj_hit && slot_free[i]) begin
          inj_hit   = 1'b1;
          slot_d[i] = {1'b0, 1'b1, head, route_port(head[5:4], head[3:2])};
        end
      end
    end
  end

  assign fifo_pop = inj_hit;

  // FIFO pointer and occupancy next-state; power-of-two depth lets pointers wrap naturally
  always_comb begin
    wr_ptr_d = fifo_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = fifo_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({fifo_push, fifo_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Output registers and FIFO control; reset discards in-flight and queued flits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) slot_q[i] <= 10'd0;
      ej_vld_q <= 1'b0;
      ej_dat_q <= 6'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) slot_q[i] <= slot_d[i];
      ej_vld_q <= ej_vld_d;
      ej_dat_q <= ej_dat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage needs no reset: occupancy alone decides what is readable
  always_ff @(posedge clk) begin
    if (fifo_push) mem_q[wr_ptr_q] <= inj_data;
  end

  assign east_pdn  = slot_q[SLOT_E];
  assign west_pdn  = slot_q[SLOT_W];
  assign north_pdn = slot_q[SLOT_N];
  assign south_pdn = slot_q[SLOT_S];
  assign ej_valid  = ej_vld_q;
  assign ej_data   = ej_dat_q;

`ifdef CHIPPER_EI_STATS_EN
  logic [15:0] stat_eject_q, stat_eject_d;
  logic [15:0] stat_defl_q, stat_defl_d;
  logic [2:0]  local_cnt;
  logic [2:0]  defl_cnt;
  logic [16:0] defl_sum;

  // Deflections are local link flits that lost eject arbitration this cycle
  always_comb begin
    local_cnt = 3'd0;
    for (int i = 0; i < 4; i++) local_cnt = local_cnt + 3'(is_local[i]);
    defl_cnt     = local_cnt - 3'(ej_hit);
    defl_sum     = {1'b0, stat_defl_q} + 17'(defl_cnt);
    stat_defl_d  = defl_sum[16] ? 16'hFFFF : defl_sum[15:0];
    stat_eject_d = (ej_hit && (stat_eject_q != 16'hFFFF)) ? stat_eject_q + 16'd1 : stat_eject_q;
  end

  // Saturating statistics counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_eject_q <= 16'd0;
      stat_defl_q  <= 16'd0;
    end else begin
      stat_eject_q <= stat_eject_d;
      stat_defl_q  <= stat_defl_d;
    end
  end

  assign stat_eject = stat_eject_q;
  assign stat_defl  = stat_defl_q;
`endif

endmodule

// File: tb/tb_chipper_eject_inject.sv
// tb_chipper_eject_inject: randomized + directed bench for chipper_eject_inject (NODE_X = NODE_Y = 1).
// Expected outputs come from a queue-based reference model of the eject/route/inject rules.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
module tb_chipper_eject_inject;

  localparam logic [1:0] NX  = 2'd1;
  localparam logic [1:0] NY  = 2'd1;
  localparam int         DEP = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] north_in, south_in, east_in, west_in;
  logic       inj_valid;
  logic [5:0] inj_data;
  logic       inj_ready;
  logic       ej_valid;
  logic [5:0] ej_data;
  logic [9:0] north_pdn, south_pdn, east_pdn, west_pdn;
`ifdef CHIPPER_EI_STATS_EN
  logic [15:0] stat_eject, stat_defl;
  int          m_stat_ej;
  int          m_stat_defl;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0] q[$];   // model of the injection FIFO contents, head first

  chipper_eject_inject #(.NODE_X(NX), .NODE_Y(NY), .INJ_DEPTH(DEP)) dut (
    .clk       (clk),
    .rst       (rst),
    .north_in  (north_in),
    .south_in  (south_in),
    .east_in   (east_in),
    .west_in   (west_in),
    .inj_valid (inj_valid),
    .inj_data  (inj_data),
    .inj_ready (inj_ready),
    .ej_valid  (ej_valid),
    .ej_data   (ej_data),
    .north_pdn (north_pdn),
    .south_pdn (south_pdn),
    .east_pdn  (east_pdn),
    .west_pdn  (west_pdn)
`ifdef CHIPPER_EI_STATS_EN
    ,
    .stat_eject(stat_eject),
    .stat_defl (stat_defl)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Desired direction from signed coordinate offsets
  function automatic logic [1:0] want_port(input logic [1:0] dx, input logic [1:0] dy);
    int ddx, ddy;
    ddx = int'(dx) - int'(NX);
    ddy = int'(dy) - int'(NY);
    if (ddx != 0) return (ddx > 0) ? 2'd0 : 2'd1;
    if (ddy != 0) return (ddy > 0) ? 2'd2 : 2'd3;
    return 2'd0;
  endfunction

  function automatic bit at_home(input logic [9:0] f);
    return f[8] && (f[7:6] == NX) && (f[5:4] == NY);
  endfunction

  // One clock: predict from current inputs and model FIFO, advance, then compare everything
  task automatic step();
    logic [9:0] lnk[4];
    logic [9:0] exp_slot[4];
    logic [9:0] act[4];
    string      nm[4];
    int         ej;
    int         nloc;
    bit         ready_pre;
    bit         injected;
    lnk = '{east_in, west_in, north_in, south_in};
    nm  = '{"east_pdn", "west_pdn", "north_pdn", "south_pdn"};
    ej   = -1;
    nloc = 0;
    for (int i = 0; i < 4; i++) if (at_home(lnk[i])) nloc++;
    for (int pass = 0; pass < 2; pass++)
      for (int i = 0; i < 4; i++)
        if (ej < 0 && at_home(lnk[i]) && (pass == 1 || lnk[i][9])) ej = i;
    for (int i = 0; i < 4; i++)
      exp_slot[i] = (!lnk[i][8] || i == ej) ? 10'd0
                    : {lnk[i][9:2], want_port(lnk[i][7:6], lnk[i][5:4])};
    ready_pre = (q.size() != DEP);
    chk("inj_ready_pre", 16'(inj_ready), 16'(ready_pre));
    injected = 0;
    if (q.size() > 0) begin
      for (int i = 0; i < 4; i++) begin
        if (!injected && !exp_slot[i][8]) begin
          exp_slot[i] = {2'b01, q[0], want_port(q[0][5:4], q[0][3:2])};
          injected = 1;
        end
      end
    end
    if (injected) void'(q.pop_front());
    if (inj_valid && ready_pre) q.push_back(inj_data);
`ifdef CHIPPER_EI_STATS_EN
    if (ej >= 0) m_stat_ej = (m_stat_ej < 65535) ? m_stat_ej + 1 : 65535;
    m_stat_defl = m_stat_defl + nloc - ((ej >= 0) ? 1 : 0);
    if (m_stat_defl > 65535) m_stat_defl = 65535;
`endif
    @(posedge clk);
    #1;
    act = '{east_pdn, west_pdn, north_pdn, south_pdn};
    for (int i = 0; i < 4; i++) chk(nm[i], 16'(act[i]), 16'(exp_slot[i]));
    chk("ej_valid", 16'(ej_valid), 16'(ej >= 0));
    chk("ej_data", 16'(ej_data), (ej >= 0) ? 16'(lnk[ej][7:2]) : 16'd0);
    chk("inj_ready", 16'(inj_ready), 16'(q.size() != DEP));
`ifdef CHIPPER_EI_STATS_EN
    chk("stat_eject", stat_eject, 16'(m_stat_ej));
    chk("stat_defl", stat_defl, 16'(m_stat_defl));
`endif
  endtask

  task automatic set_links(input logic [9:0] e, input logic [9:0] w, input logic [9:0] n, input logic [9:0] s);
    east_in = e; west_in = w; north_in = n; south_in = s;
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear without waiting for a clock
  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_east", 16'(east_pdn), 16'd0);
    chk("rst_west", 16'(west_pdn), 16'd0);
    chk("rst_north", 16'(north_pdn), 16'd0);
    chk("rst_south", 16'(south_pdn), 16'd0);
    chk("rst_ej_valid", 16'(ej_valid), 16'd0);
    chk("rst_ej_data", 16'(ej_data), 16'd0);
    chk("rst_inj_ready", 16'(inj_ready), 16'd1);
    q.delete();
`ifdef CHIPPER_EI_STATS_EN
    m_stat_ej = 0;
    m_stat_defl = 0;
`endif
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [9:0] rnd_flit(input int pvalid);
    logic [9:0] f;
    f    = 10'($urandom);
    f[8] = ($urandom_range(99) < pvalid);
    if ($urandom_range(3) == 0) begin
      f[7:6] = NX;
      f[5:4] = NY;
    end
    return f;
  endfunction

  localparam logic [9:0] FULL_FLIT = 10'b0100000000;  // dest (0,0): routed west

  initial begin
    int pv;
`ifdef CHIPPER_EI_STATS_EN
    m_stat_ej = 0;
    m_stat_defl = 0;
`endif
    rst = 1'b1;
    set_links(10'd0, 10'd0, 10'd0, 10'd0);
    inj_valid = 1'b0;
    inj_data  = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_east", 16'(east_pdn), 16'd0);
    chk("reset_ej_valid", 16'(ej_valid), 16'd0);
    chk("reset_inj_ready", 16'(inj_ready), 16'd1);
    rst = 1'b0;

    // 1: single local flit ejected
    set_links(10'b0101011000, 10'd0, 10'd0, 10'd0);
    step();
    chk("t1_ej_valid", 16'(ej_valid), 16'd1);
    chk("t1_ej_data", 16'(ej_data), 16'b010110);
    chk("t1_east", 16'(east_pdn), 16'd0);

    // 2: routing of non-local flits
    set_links(10'd0, 10'b0111001100, 10'b0100100100, 10'd0);
    step();
    chk("t2_west", 16'(west_pdn), 16'b0111001100);
    chk("t2_north", 16'(north_pdn), 16'b0100100101);

    // 3: golden north beats non-golden east; east is deflected with port 0
    set_links(10'b0101011000, 10'd0, 10'b1101010100, 10'd0);
    step();
    chk("t3_ej_data", 16'(ej_data), 16'b010101);
    chk("t3_east", 16'(east_pdn), 16'b0101011000);
    chk("t3_north", 16'(north_pdn), 16'd0);

    // 4: injection into empty link slots
    set_links(10'd0, 10'd0, 10'd0, 10'd0);
    inj_valid = 1'b1; inj_data = 6'b110100;
    step();
    inj_valid = 1'b0;
    step();
    chk("t4_east_inj", 16'(east_pdn), 16'b0111010000);
    inj_valid = 1'b1; inj_data = 6'b000111;
    step();
    inj_valid = 1'b0;
    step();
    chk("t4_east_inj2", 16'(east_pdn), 16'b0100011101);

    // 5: all slots busy and non-local; FIFO fills, then a freed south slot takes the head
    set_links(FULL_FLIT, FULL_FLIT, FULL_FLIT, FULL_FLIT);
    inj_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      inj_data = (k == 0) ? 6'b100100 : 6'(k + 8);
      step();
    end
    chk("t5_full", 16'(inj_ready), 16'd0);
    inj_valid = 1'b0;
    set_links(FULL_FLIT, FULL_FLIT, FULL_FLIT, 10'd0);
    step();
    chk("t5_south_inj", 16'(south_pdn), 16'b0110010000);
    chk("t5_ready_back", 16'(inj_ready), 16'd1);

    // 6: reset with three flits queued, then confirm nothing stale comes out
    set_links(FULL_FLIT, FULL_FLIT, FULL_FLIT, FULL_FLIT);
    step();
    mid_reset();
    set_links(10'd0, 10'd0, 10'd0, 10'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_no_stale", 16'(east_pdn), 16'd0);
    end

    // Randomized traffic at varying link load, one extra reset in the middle
    for (int blk = 0; blk < 20; blk++) begin
      pv = (blk % 3 == 0) ? 100 : ((blk % 3 == 1) ? 70 : 30);
      for (int c = 0; c < 100; c++) begin
        set_links(rnd_flit(pv), rnd_flit(pv), rnd_flit(pv), rnd_flit(pv));
        inj_valid = ($urandom_range(99) < 60);
        inj_data  = 6'($urandom);
        step();
      end
      if (blk == 10) mid_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
